// File: rtl/cpu_timing_pkg.sv
// Shared beat-timing types and constants for the hardwired controller slice.
package cpu_timing_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    W1   = 2'd1,
    W2   = 2'd2,
    W3   = 2'd3
  } beat_state_t;

  localparam int SHORT_BEATS  = 1;
  localparam int NORMAL_BEATS = 2;
  localparam int LONG_BEATS   = 3;

  // True on the beat that closes the current machine cycle.
  function automatic logic is_cycle_end(input beat_state_t s, input logic sh, input logic lg);
    return ((s == W1) && sh) || ((s == W2) && !lg) || (s == W3);
  endfunction

endpackage

// File: rtl/qd_edge_detect.sv
// Rising-edge detector for a level input; the register resets high so a
// level already present at reset release is not seen as an edge.
module qd_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (rst) d_q <= 1'b1;
    else     d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/beat_timing_gen.sv
// Beat generator W1/W2/W3 for the hardwired controller, clocked by t3.
// Optional single-cycle step switch dp is enabled by BEAT_STEP_MODE_EN.
module beat_timing_gen
  import cpu_timing_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter bit AUTO_START = 1'b0
) (
  input  logic             t3,
  input  logic             clr,
  input  logic             short,
  input  logic             long,
  input  logic             stop,
  input  logic             qd,
`ifdef BEAT_STEP_MODE_EN
  input  logic             dp,
`endif
  output logic             w1,
  output logic             w2,
  output logic             w3,
  output logic             running,
  output logic             cycle_done,
  output logic [CNT_W-1:0] cycle_cnt
);

  // short/long/stop are plain levels sampled on the t3 edge that ends a beat;
  // there is no handshake, the controller holds them stable across the beat.
  beat_state_t state_q, state_d;
  logic        qd_rise;
  logic        first_q;
  logic        halt;

  qd_edge_detect u_qd_edge (
    .clk  (t3),
    .rst  (clr),
    .d    (qd),
    .rise (qd_rise)
  );

`ifdef BEAT_STEP_MODE_EN
  assign halt = stop | dp;
`else
  assign halt = stop;
`endif

  always_comb begin
    state_d    = state_q;
    cycle_done = is_cycle_end(state_q, short, long);
    case (state_q)
      IDLE: if (qd_rise || (AUTO_START && first_q)) state_d = W1;
      W1:   state_d = W2;
      W2:   state_d = W3;
      W3:   state_d = W1;
      default: state_d = IDLE;
    endcase
    if (cycle_done) state_d = halt ? IDLE : W1;
  end

  always_ff @(posedge t3) begin
    if (clr) begin
      state_q   <= IDLE;
      first_q   <= 1'b1;
      cycle_cnt <= '0;
    end else begin
      state_q <= state_d;
      first_q <= 1'b0;
      if (cycle_done) cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

  assign w1      = (state_q == W1);
  assign w2      = (state_q == W2);
  assign w3      = (state_q == W3);
  assign running = (state_q != IDLE);

endmodule

// File: tb/tb_beat_timing_gen.sv
// Scoreboard bench for beat_timing_gen: a beat-count reference model pushes
// expected outputs per t3 period, a negedge monitor pops and compares.
module tb_beat_timing_gen;

  localparam int CNT_W = 4;
`ifdef BEAT_STEP_MODE_EN
  localparam bit STEP_BUILD = 1'b1;
`else
  localparam bit STEP_BUILD = 1'b0;
`endif

  logic t3 = 1'b0;
  logic clr, short, long, stop, qd, dp;
  logic w1, w2, w3, running, cycle_done;
  logic [CNT_W-1:0] cycle_cnt;
  logic a_w1, a_w2, a_w3, a_running, a_done;
  logic [15:0] a_cnt;

  int checks = 0;
  int failures = 0;

  // {chk, w3, w2, w1, running, cycle_done, cycle_cnt}
  logic [9:0] exp_q[$];

  // reference model state
  int m_beat = 0;
  int m_cnt = 0;
  bit m_prevqd = 1'b1;
  bit m_first = 1'b1;
  bit m_valid = 1'b0;

  always #5 t3 = ~t3;

  beat_timing_gen #(.CNT_W(CNT_W), .AUTO_START(1'b0)) dut (
    .t3(t3), .clr(clr), .short(short), .long(long), .stop(stop), .qd(qd),
`ifdef BEAT_STEP_MODE_EN
    .dp(dp),
`endif
    .w1(w1), .w2(w2), .w3(w3), .running(running),
    .cycle_done(cycle_done), .cycle_cnt(cycle_cnt)
  );

  beat_timing_gen #(.CNT_W(16), .AUTO_START(1'b1)) dut_auto (
    .t3(t3), .clr(clr), .short(short), .long(long), .stop(stop), .qd(qd),
`ifdef BEAT_STEP_MODE_EN
    .dp(dp),
`endif
    .w1(a_w1), .w2(a_w2), .w3(a_w3), .running(a_running),
    .cycle_done(a_done), .cycle_cnt(a_cnt)
  );

  function automatic bit ends_now(int beat, logic s, logic l);
    return (beat == 1 && s) || (beat == 2 && !l) || (beat == 3);
  endfunction

  // Drive one t3 period of inputs, record expectation, advance the model.
  task automatic step(input logic c, input logic s, input logic l,
                      input logic p, input logic q, input logic d);
    logic [9:0] e;
    bit fin;
    clr = c; short = s; long = l; stop = p; qd = q; dp = d;
    fin = ends_now(m_beat, s, l);
    e = {m_valid, (m_beat == 3), (m_beat == 2), (m_beat == 1), (m_beat != 0),
         fin, 4'(m_cnt)};
    exp_q.push_back(e);
    @(posedge t3);
    if (c) begin
      m_beat = 0; m_cnt = 0; m_prevqd = 1'b1; m_first = 1'b1; m_valid = 1'b1;
    end else begin
      if (m_beat == 0) begin
        if (q && !m_prevqd) m_beat = 1;
      end else if (fin) begin
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
        m_beat = (p || (STEP_BUILD && d)) ? 0 : 1;
      end else begin
        m_beat = m_beat + 1;
      end
      m_prevqd = q;
      m_first = 1'b0;
    end
    #1;
  endtask

  always @(negedge t3) begin
    logic [9:0] e;
    logic [8:0] act;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = {w3, w2, w1, running, cycle_done, cycle_cnt};
      if (e[9]) begin
        checks++;
        if (act !== e[8:0]) begin
          failures++;
          $display("FAIL beat_outputs t=%0t w321 got=%b exp=%b run got=%b exp=%b done got=%b exp=%b cnt got=%0d exp=%0d",
                   $time, act[8:6], e[8:6], act[5], e[5], act[4], e[4], act[3:0], e[3:0]);
        end
      end
    end
  end

  initial begin
    @(posedge t3); #1;
    // reset with qd held; the held button must not start the machine
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    checks++;
    if (!(a_w1 && a_running)) begin
      failures++;
      $display("FAIL auto_start_w1 got w1=%b run=%b exp w1=1 run=1", a_w1, a_running);
    end
    step(0, 0, 0, 0, 1, 0);
    checks++;
    if (!a_w2) begin
      failures++;
      $display("FAIL auto_start_w2 got w2=%b exp 1", a_w2);
    end
    step(0, 0, 0, 0, 1, 0);
    // release then press: normal W1/W2 cycles
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0, 0);
    // short cycles, enough to wrap the 4-bit counter
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0, 0);
    // long cycle with stop raised in W1, then restart with qd
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);
    // reset mid-cycle
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // short and long together, then stop and qd on the same cycle end
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);
    // step switch: each qd press runs one machine cycle when enabled
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1, 1);
      for (int i = 0; i < 4; i++) step(0, k == 2, k == 1, 0, 0, 1);
    end
    // randomized traffic
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
    @(negedge t3); #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d left exp 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/beat_timing_gen.md
Name: beat_timing_gen

Overview:
- Generates the one-hot beat signals w1/w2/w3 consumed by the hardwired controller `cpu`.
- Responds to the controller's cycle-length requests (short, long) and its stop request.
- Resumes on the front-panel start button qd.
- Clocked by t3, so each beat lasts exactly one t3 period; sits between the panel/clock logic and `cpu`.

Parameters:
- CNT_W, 16, width of the completed-machine-cycle counter cycle_cnt.
- AUTO_START, 0, 1 = leave IDLE on the first edge after reset without waiting for qd.

Ports:
- t3  input  1  clock; every state update happens on its rising edge.
- clr  input  1  synchronous reset, active-high.
- short  input  1  from `cpu`: the current machine cycle is W1 only.
- long  input  1  from `cpu`: the current machine cycle extends to W3.
- stop  input  1  from `cpu`: halt at the end of the current machine cycle.
- qd  input  1  debounced start button, level.
- w1  output  1  beat 1 active.
- w2  output  1  beat 2 active.
- w3  output  1  beat 3 active.
- running  output  1  high in any W state, low in IDLE.
- cycle_done  output  1  one-t3 pulse on the beat that ends a machine cycle.
- cycle_cnt  output  CNT_W  number of completed machine cycles, wraps.

Behaviour:
- States: IDLE, W1, W2, W3. Outputs w1/w2/w3 are decoded from the registered state and are one-hot or all-zero.
- Reset (clr=1 at an edge):
  - state=IDLE; w1=w2=w3=0; running=0; cycle_done=0; cycle_cnt=0.
  - qd_q=1, so a button held through reset does not start the machine.
  - Reset mid-beat aborts the cycle without incrementing cycle_cnt.
- qd_rise = qd & ~qd_q. qd_q is registered every edge.
- IDLE:
  - Go to W1 on qd_rise, or on the first non-reset edge when AUTO_START=1.
  - Otherwise hold.
  - qd_rise outside IDLE is ignored.
- short, long and stop are sampled at the edge that ends the current beat.
- W1: short=1 ends the cycle; otherwise go to W2.
- W2: long=1 goes to W3; otherwise the cycle ends.
- W3: the cycle always ends; short and long are ignored.
- Cycle end:
  - cycle_done=1 during the final beat (combinational from state, short and long).
  - cycle_cnt increments at that edge; it wraps from 2^CNT_W-1 to 0.
  - Next state is IDLE if stop=1, otherwise W1.
- stop is ignored at any edge that is not a cycle end; stop raised during W1 of a long cycle takes effect at the end of W3.
- short and long both 1 in W1: short wins, cycle ends after W1.
- Latency: qd_rise at edge k makes w1=1 in the t3 period following edge k.
- stop and qd_rise at the same cycle-end edge: go to IDLE, and that qd edge is not remembered.

Optional Feature:
- Macro: BEAT_STEP_MODE_EN.
- Defined: adds input dp (single-cycle step switch). While dp=1, every cycle end goes to IDLE as if stop=1; each qd_rise runs exactly one machine cycle.
- Undefined: no dp port; only stop halts.

Decomposition:
- Shared package cpu_timing_pkg:
  - beat_state_t enum {IDLE, W1, W2, W3}, 2-bit encoding.
  - Beat count constants SHORT_BEATS=1, NORMAL_BEATS=2, LONG_BEATS=3.
- Sub-module qd_edge_detect: one register plus rise output, reset value 1. Reused by the panel logic.

Test Plan:
- Reset then qd pulse, short=0, long=0, stop=0 → w sequence w1,w2,w1,w2,…; cycle_done high in each W2; cycle_cnt=3 after 6 beats.
- short=1 from start → w1 stays high continuously; cycle_cnt increments every t3; CNT_W=4 wraps 15→0 after 16 cycles.
- long=1 in W2, then stop=1 asserted during W1 → w1,w2,w3 then IDLE with all w=0; running=0; cycle_cnt=1; a new qd pulse restarts at W1.
- qd held high through reset release → remains IDLE; release then re-press qd → W1 one edge after the press.
- clr=1 during W2 → IDLE next edge, cycle_cnt=0; AUTO_START=1 build → W1 on the first edge after clr falls, no qd needed.
- BEAT_STEP_MODE_EN, dp=1 → each qd pulse yields exactly one cycle (w1,w2 then IDLE); short=1 and long=1 together in W1 → single-beat cycle.
